// File: rtl/div_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_4bit_seq
// Brief    : Sequential restoring shift-subtract unsigned divider, one
//            quotient bit per cycle. Optional macro DIV4_DIVZERO_FAST_EN
//            short-cuts divide-by-zero straight to DONE with err=1.
// Revision : 1.0
// ============================================================================
module div_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH:0]     r_prem;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_fast;
  logic               w_last;
  logic               w_qbit;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_prem_nxt;
  logic [WIDTH-1:0]   w_dvd_nxt;

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));

`ifdef DIV4_DIVZERO_FAST_EN
  assign w_fast = w_accept && (divisor == '0);
`else
  assign w_fast = 1'b0;
`endif

  // The dividend register doubles as the quotient shift register; a set top
  // partial-remainder bit would mean the shifted value already exceeds the divisor.
  assign w_shift    = {r_prem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = r_prem[WIDTH] || (w_shift >= {1'b0, r_dvs});
  assign w_prem_nxt = w_qbit ? w_diff : w_shift;
  assign w_dvd_nxt  = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_fast) begin
          w_state_nxt = ST_DONE;
        end else if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_prem    <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (w_accept) begin
        r_dvd  <= dividend;
        r_dvs  <= divisor;
        r_prem <= '0;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_dvd  <= w_dvd_nxt;
        r_prem <= w_prem_nxt;
        r_cnt  <= r_cnt + c_CNT_W'(1);
        if (w_last) begin
          quotient  <= w_dvd_nxt;
          remainder <= w_prem_nxt[WIDTH-1:0];
        end
      end
      if (w_fast) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end
  end

`ifdef DIV4_DIVZERO_FAST_EN
  logic r_err;

  // DONE lasts one cycle, so err only ever marks the fast-path result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_fast;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire
